// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state codes (IEEE 1149.1 table), default opcodes and the TAP next-state function
package jtag_tap_pkg;
   typedef logic [3:0] tap_state_t;
   localparam tap_state_t TLR      = 4'hF;
   localparam tap_state_t RTI      = 4'hC;
   localparam tap_state_t SEL_DR   = 4'h7;
   localparam tap_state_t CAP_DR   = 4'h6;
   localparam tap_state_t SHIFT_DR = 4'h2;
   localparam tap_state_t EXIT1_DR = 4'h1;
   localparam tap_state_t PAUSE_DR = 4'h3;
   localparam tap_state_t EXIT2_DR = 4'h0;
   localparam tap_state_t UPD_DR   = 4'h5;
   localparam tap_state_t SEL_IR   = 4'h4;
   localparam tap_state_t CAP_IR   = 4'hE;
   localparam tap_state_t SHIFT_IR = 4'hA;
   localparam tap_state_t EXIT1_IR = 4'h9;
   localparam tap_state_t PAUSE_IR = 4'hB;
   localparam tap_state_t EXIT2_IR = 4'h8;
   localparam tap_state_t UPD_IR   = 4'hD;
   localparam int          IR_LEN_DEF    = 4;
   localparam int          USER_W_DEF    = 32;
   localparam logic [31:0] IDCODE_DEF    = 32'h1234_5001;
   localparam logic [3:0]  OP_IDCODE_DEF = 4'b0001;
   localparam logic [3:0]  OP_USER_DEF   = 4'b1000;
   function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
      case (s)
         TLR:      next_state = tms ? TLR      : RTI;
         RTI:      next_state = tms ? SEL_DR   : RTI;
         SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   next_state = tms ? SEL_DR   : RTI;
         SEL_IR:   next_state = tms ? TLR      : CAP_IR;
         CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   next_state = tms ? SEL_DR   : RTI;
         default:  next_state = TLR;
      endcase
   endfunction
endpackage

// File: rtl/jtag_tap_responder_if.sv
// jtag_tap_responder_if: JTAG pins, TAP status and USER data exchange between host side and TAP
interface jtag_tap_responder_if #(parameter int IR_LEN = 4, parameter int USER_W = 32);
   logic              jtag_tck;
   logic              jtag_tms;
   logic              jtag_tdi;
   logic              jtag_tdo;
   logic              jtag_tdo_oe;
   logic [3:0]        tap_state;
   logic [IR_LEN-1:0] ir;
   logic [USER_W-1:0] user_in;
   logic [USER_W-1:0] user_out;
   logic              user_update;
   modport master (output jtag_tck, jtag_tms, jtag_tdi, user_in,
                   input  jtag_tdo, jtag_tdo_oe, tap_state, ir, user_out, user_update);
   modport slave  (input  jtag_tck, jtag_tms, jtag_tdi, user_in,
                   output jtag_tdo, jtag_tdo_oe, tap_state, ir, user_out, user_update);
endinterface

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: 2-FF synchronizers on TCK/TMS/TDI plus TCK rise/fall strobes
module jtag_pin_sync (
   input  logic clk_25mhz,
   input  logic reset,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tms_s,
   output logic tdi_s,
   output logic tck_rise,
   output logic tck_fall
);
   logic [1:0] tck_q, tms_q, tdi_q;
   logic       tck_d;
   logic [2:0] arm;
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         tck_q <= '0;
         tms_q <= '0;
         tdi_q <= '0;
         tck_d <= 1'b0;
         arm   <= '0;
      end else begin
         tck_q <= {tck_q[0], tck};
         tms_q <= {tms_q[0], tms};
         tdi_q <= {tdi_q[0], tdi};
         tck_d <= tck_q[1];
         arm   <= {arm[1:0], 1'b1};
      end
   end
   // Strobes stay masked until the pipeline holds real pin history, so a TCK idling high is no edge
   assign tck_rise = arm[2] & tck_q[1] & ~tck_d;
   assign tck_fall = arm[2] & ~tck_q[1] & tck_d;
   assign tms_s    = tms_q[1];
   assign tdi_s    = tdi_q[1];
endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: fabric JTAG TAP with IDCODE, BYPASS and USER data registers
module jtag_tap_responder
   import jtag_tap_pkg::*;
#(
   parameter int          IR_LEN    = IR_LEN_DEF,
   parameter logic [31:0] IDCODE    = IDCODE_DEF,
   parameter int          USER_W    = USER_W_DEF,
   parameter logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(OP_IDCODE_DEF),
   parameter logic [IR_LEN-1:0] OP_USER   = IR_LEN'(OP_USER_DEF)
) (
   input logic                  clk_25mhz,
   input logic                  reset,
   jtag_tap_responder_if.slave  bus
);
   tap_state_t        state;
   logic [IR_LEN-1:0] ir_q, ir_sr;
   logic [31:0]       id_sr;
   logic [USER_W-1:0] user_sr, uout;
   logic              byp, tdo, oe, upd;
   logic              tms, tdi, rise, fall;
   logic              sel_id, sel_user, shifting, dr_lsb;
   jtag_pin_sync u_sync (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .tck       (bus.jtag_tck),
      .tms       (bus.jtag_tms),
      .tdi       (bus.jtag_tdi),
      .tms_s     (tms),
      .tdi_s     (tdi),
      .tck_rise  (rise),
      .tck_fall  (fall)
   );
   assign sel_id   = ir_q == OP_IDCODE;
   assign sel_user = ir_q == OP_USER;
   assign shifting = state == SHIFT_IR || state == SHIFT_DR;
   assign dr_lsb   = sel_id ? id_sr[0] : sel_user ? user_sr[0] : byp;
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state   <= TLR;
         ir_q    <= OP_IDCODE;
         ir_sr   <= '0;
         id_sr   <= '0;
         user_sr <= '0;
         uout    <= '0;
         byp     <= 1'b0;
         tdo     <= 1'b0;
         oe      <= 1'b0;
         upd     <= 1'b0;
      end else begin
         upd <= fall && state == UPD_DR && sel_user;
         if (rise) begin
            state <= next_state(state, tms);
            if (state == CAP_IR) ir_sr <= IR_LEN'(1);
            if (state == SHIFT_IR) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
            if (state == CAP_DR) begin
               if (sel_id) id_sr <= IDCODE;
               else if (sel_user) user_sr <= bus.user_in;
               else byp <= 1'b0;
            end
            if (state == SHIFT_DR) begin
               if (sel_id) id_sr <= {tdi, id_sr[31:1]};
               else if (sel_user) user_sr <= {tdi, user_sr[USER_W-1:1]};
               else byp <= tdi;
            end
         end
         // Updates land on the falling strobe, the classic 1149.1 timing for Update-IR/DR
         if (fall) begin
            if (shifting) tdo <= state == SHIFT_IR ? ir_sr[0] : dr_lsb;
            oe <= shifting;
            if (state == UPD_IR) ir_q <= ir_sr;
            if (state == UPD_DR && sel_user) uout <= user_sr;
         end
         if (state == TLR) ir_q <= OP_IDCODE;
      end
   end
   assign bus.jtag_tdo    = tdo;
   assign bus.jtag_tdo_oe = oe;
   assign bus.tap_state   = state;
   assign bus.ir          = ir_q;
   assign bus.user_out    = uout;
   assign bus.user_update = upd;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed TAP scans driven on pins at TCK = clk/10, checked against hand values
module tb_jtag_tap_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   pass_cnt = 0, total_cnt = 0, upd_cycles = 0;
   jtag_tap_responder_if bus ();
   jtag_tap_responder dut (.clk_25mhz(clk), .reset(reset), .bus(bus));
   always #20 clk = ~clk;
   always @(posedge clk) if (bus.user_update) upd_cycles <= upd_cycles + 1;
   typedef struct {
      logic [3:0]  irv;
      logic [31:0] uin;
      logic [31:0] din;
      int          n;
      logic [31:0] tdo;
      logic [31:0] uout;
      int          upd;
   } vec_t;
   vec_t v [6];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic tck(input logic tms, input logic tdi, output logic o, output logic oe);
      bus.jtag_tms = tms;
      bus.jtag_tdi = tdi;
      wait_clk(5);
      o  = bus.jtag_tdo;
      oe = bus.jtag_tdo_oe;
      bus.jtag_tck = 1'b1;
      wait_clk(5);
      bus.jtag_tck = 1'b0;
   endtask
   task automatic step(input logic tms);
      logic a, b;
      tck(tms, 1'b0, a, b);
   endtask
   task automatic scan_ir(input logic [3:0] val, output logic [3:0] o, output logic [3:0] oe);
      logic a, b;
      o = '0;
      oe = '0;
      step(1); step(1); step(0); step(0);
      for (int i = 0; i < 4; i++) begin
         tck(i == 3, val[i], a, b);
         o[i] = a;
         oe[i] = b;
      end
      step(1); step(0);
      wait_clk(6);
   endtask
   task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] o);
      logic a, b;
      o = '0;
      step(1); step(0); step(0);
      for (int i = 0; i < n; i++) begin
         tck(i == n - 1, din[i], a, b);
         o[i] = a;
      end
      step(1); step(0);
      wait_clk(6);
   endtask
   initial begin
      logic [31:0] dout;
      logic [3:0]  irt, oes;
      int          u0;
      v[0] = '{4'b0001, 32'h0,         32'h0,         32, 32'h1234_5001, 32'h0,         0};
      v[1] = '{4'b1111, 32'h0,         32'h5,          3, 32'h2,         32'h0,         0};
      v[2] = '{4'b1000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1};
      v[3] = '{4'b0101, 32'h0,         32'h3,          4, 32'h6,         32'hCAFE_F00D, 0};
      v[4] = '{4'b1000, 32'h0F0F_1234, 32'h8000_0001, 32, 32'h0F0F_1234, 32'h8000_0001, 1};
      v[5] = '{4'b0001, 32'h0,         32'hFF,         8, 32'h01,        32'h8000_0001, 0};
      bus.jtag_tck = 1'b1;
      bus.jtag_tms = 1'b0;
      bus.jtag_tdi = 1'b0;
      bus.user_in  = '0;
      wait_clk(4);
      chk("rst_state", 32'(bus.tap_state), 32'hF);
      chk("rst_ir", 32'(bus.ir), 32'h1);
      chk("rst_tdo", 32'(bus.jtag_tdo), 32'h0);
      chk("rst_oe", 32'(bus.jtag_tdo_oe), 32'h0);
      chk("rst_uout", bus.user_out, 32'h0);
      chk("rst_upd", 32'(bus.user_update), 32'h0);
      reset = 1'b0;
      wait_clk(10);
      chk("no_spurious_edge", 32'(bus.tap_state), 32'hF);
      bus.jtag_tck = 1'b0;
      wait_clk(5);
      step(0);
      chk("rti_state", 32'(bus.tap_state), 32'hC);
      chk("rti_ir", 32'(bus.ir), 32'h1);
      scan_dr(32'h0, 32, dout);
      chk("idcode_default", dout, 32'h1234_5001);
      chk("idle_oe", 32'(bus.jtag_tdo_oe), 32'h0);
      for (int k = 0; k < 6; k++) begin
         bus.user_in = v[k].uin;
         scan_ir(v[k].irv, irt, oes);
         chk($sformatf("v%0d_ir_capture", k), 32'(irt), 32'h1);
         chk($sformatf("v%0d_ir_oe", k), 32'(oes), 32'hF);
         chk($sformatf("v%0d_ir", k), 32'(bus.ir), 32'(v[k].irv));
         u0 = upd_cycles;
         scan_dr(v[k].din, v[k].n, dout);
         chk($sformatf("v%0d_tdo", k), dout, v[k].tdo);
         chk($sformatf("v%0d_uout", k), bus.user_out, v[k].uout);
         chk($sformatf("v%0d_upd_cycles", k), 32'(upd_cycles - u0), 32'(v[k].upd));
         chk($sformatf("v%0d_state", k), 32'(bus.tap_state), 32'hC);
      end
      bus.user_in = 32'h5555_AAAA;
      scan_ir(4'b1000, irt, oes);
      step(1); step(0); step(0);
      for (int i = 0; i < 10; i++) step(0);
      chk("mid_shift_oe", 32'(bus.jtag_tdo_oe), 32'h1);
      u0 = upd_cycles;
      reset = 1'b1;
      wait_clk(1);
      chk("midrst_state", 32'(bus.tap_state), 32'hF);
      chk("midrst_oe", 32'(bus.jtag_tdo_oe), 32'h0);
      chk("midrst_uout", bus.user_out, 32'h0);
      chk("midrst_ir", 32'(bus.ir), 32'h1);
      reset = 1'b0;
      wait_clk(6);
      chk("midrst_no_upd", 32'(upd_cycles - u0), 32'h0);
      step(0);
      scan_ir(4'b1000, irt, oes);
      chk("pre_pause_ir", 32'(bus.ir), 32'h8);
      step(1); step(0); step(0); step(1); step(0);
      chk("pause_dr", 32'(bus.tap_state), 32'h3);
      for (int i = 0; i < 5; i++) step(1);
      wait_clk(5);
      chk("tms5_state", 32'(bus.tap_state), 32'hF);
      chk("tms5_ir", 32'(bus.ir), 32'h1);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
